// File: rtl/var_state_bin_loader.sv
// rtl/var_state_bin_loader.sv - moves per-variable state words between bin memory and the var_state8 tree
//
// Purpose:
//   Sequencer between the bin manager and the engine's variable-state array.
//   Load: reads NUM_VARS words of bin bin_id_i from memory and writes each one
//   into the engine through wr_states_o / vars_states_o.
//   Store: snapshots vars_states_i on the accept edge and writes it back to
//   memory, one variable per cycle.
//
// Optional feature macro: VAR_STATE_LOADER_MAX_LVL_EN
//   Defined     -> max_lvl_o tracks the highest lvl field among loaded words.
//   Not defined -> max_lvl_o is tied to 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_load_i    one-cycle load request (wins over start_store_i)
//   start_store_i   one-cycle store request
//   bin_id_i        target bin, latched on the accept cycle
//   busy_o          operation in progress
//   done_o          one-cycle completion pulse
//   max_lvl_o       highest loaded lvl (feature macro) or 0
//   mem_rd_en_o     memory read strobe, data valid on mem_rdata_i one cycle later
//   mem_wr_en_o     memory write strobe
//   mem_addr_o      word address = bin_id*NUM_VARS + k, truncated
//   mem_wdata_o     memory write data
//   mem_rdata_i     memory read data
//   wr_states_o     one-hot engine write enable, variable k -> bit NUM_VARS-1-k
//   vars_states_o   state bus to the engine, variable 0 in the MSB slice
//   vars_states_i   state bus from the engine

module var_state_bin_loader #(
    parameter int NUM_VARS         = 8,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 8,
    parameter int ADDR_WIDTH       = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic                                 start_store_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [WIDTH_LVL-1:0]                 max_lvl_o,
    output logic                                 mem_rd_en_o,
    output logic                                 mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]          mem_wdata_o,
    input  logic [WIDTH_VAR_STATES-1:0]          mem_rdata_i,
    output logic [NUM_VARS-1:0]                  wr_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i
);

    localparam int W  = WIDTH_VAR_STATES;
    localparam int KW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int FW = WIDTH_BIN_ID + KW;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_VARS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_LOAD_TAIL = 3'd2,
        S_STORE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [WIDTH_BIN_ID-1:0] bin_q, bin_d;
    logic [W*NUM_VARS-1:0]   snap_q, snap_d;

    logic                    rd_en_q, rd_en_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [W-1:0]            wdata_q, wdata_d;
    logic [NUM_VARS-1:0]     wr_states_q, wr_states_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [FW-1:0]           full_addr;
    logic [W*NUM_VARS-1:0]   vars_bus;

    // State register: FSM state, transfer index, latched bin and store snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            bin_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            bin_q   <= bin_d;
            snap_q  <= snap_d;
        end
    end

    // Next-state logic. k_q is the index of the word being read or written in
    // the current LOAD / STORE cycle.
    always_comb begin
        state_d = state_q;
        k_d     = '0;
        bin_d   = bin_q;
        snap_d  = snap_q;
        case (state_q)
            S_IDLE: begin
                if (start_load_i) begin
                    state_d = S_LOAD;
                    bin_d   = bin_id_i;
                end else if (start_store_i) begin
                    state_d = S_STORE;
                    bin_d   = bin_id_i;
                    snap_d  = vars_states_i;
                end
            end
            S_LOAD: begin
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_LOAD_TAIL;
                end
            end
            S_LOAD_TAIL: begin
                state_d = S_DONE;
            end
            S_STORE: begin
                k_d = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the
    // next state so strobes line up with the cycle the FSM is in.
    always_comb begin
        rd_en_d     = (state_d == S_LOAD);
        wr_en_d     = (state_d == S_STORE);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        full_addr   = {bin_d, k_d};
        addr_d      = '0;
        wdata_d     = '0;
        wr_states_d = '0;
        if (rd_en_d || wr_en_d) begin
            addr_d = ADDR_WIDTH'(full_addr);
        end
        if (wr_en_d) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (k_d == KW'(i)) begin
                    wdata_d = snap_d[W*(NUM_VARS-i)-1 -: W];
                end
            end
        end
        // The word read in this LOAD cycle comes back next cycle; arm its
        // engine enable for that cycle.
        if (state_q == S_LOAD) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (k_q == KW'(i)) begin
                    wr_states_d[NUM_VARS-1-i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_states_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_states_q <= wr_states_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // The returned word is steered into its slice in the cycle it arrives,
    // gated by the registered one-hot enable so every other slice (and the
    // whole bus outside a load) reads as 0.
    always_comb begin
        vars_bus = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (wr_states_q[NUM_VARS-1-i]) begin
                vars_bus[W*(NUM_VARS-i)-1 -: W] = mem_rdata_i;
            end
        end
    end

`ifdef VAR_STATE_LOADER_MAX_LVL_EN
    logic                 accept_load;
    logic [WIDTH_LVL-1:0] max_lvl_q;

    assign accept_load = (state_q == S_IDLE) && start_load_i;

    // Running maximum of the lvl field over forwarded words; cleared on each
    // load accept and untouched by stores.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_lvl_q <= '0;
        end else if (accept_load) begin
            max_lvl_q <= '0;
        end else if ((|wr_states_q) && (mem_rdata_i[WIDTH_LVL-1:0] > max_lvl_q)) begin
            max_lvl_q <= mem_rdata_i[WIDTH_LVL-1:0];
        end
    end

    assign max_lvl_o = max_lvl_q;
`else
    assign max_lvl_o = '0;
`endif

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mem_rd_en_o   = rd_en_q;
    assign mem_wr_en_o   = wr_en_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign wr_states_o   = wr_states_q;
    assign vars_states_o = vars_bus;

endmodule

// File: tb/tb_var_state_bin_loader.sv
// tb/tb_var_state_bin_loader.sv - directed self-checking bench for var_state_bin_loader

module tb_var_state_bin_loader;

    localparam int N   = 8;
    localparam int W   = 19;
    localparam int LVL = 16;
    localparam int BW  = 8;
    localparam int AW  = 10;

`ifdef VAR_STATE_LOADER_MAX_LVL_EN
    localparam bit MAXEN = 1'b1;
`else
    localparam bit MAXEN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start_load_i;
    logic           start_store_i;
    logic [BW-1:0]  bin_id_i;
    logic           busy_o;
    logic           done_o;
    logic [LVL-1:0] max_lvl_o;
    logic           mem_rd_en_o;
    logic           mem_wr_en_o;
    logic [AW-1:0]  mem_addr_o;
    logic [W-1:0]   mem_wdata_o;
    logic [W-1:0]   mem_rdata_i;
    logic [N-1:0]   wr_states_o;
    logic [W*N-1:0] vars_states_o;
    logic [W*N-1:0] vars_states_i;

    logic [W-1:0]   mem  [0:(1<<AW)-1];
    logic [W-1:0]   wmem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    var_state_bin_loader #(
        .NUM_VARS(N), .WIDTH_VAR_STATES(W), .WIDTH_LVL(LVL),
        .WIDTH_BIN_ID(BW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .start_store_i(start_store_i),
        .bin_id_i(bin_id_i), .busy_o(busy_o), .done_o(done_o),
        .max_lvl_o(max_lvl_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .wr_states_o(wr_states_o), .vars_states_o(vars_states_o),
        .vars_states_i(vars_states_i)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (rst) mem_rdata_i <= '0;
        else if (mem_rd_en_o) mem_rdata_i <= mem[mem_addr_o];
        if (mem_wr_en_o) wmem[mem_addr_o] <= mem_wdata_o;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pat(input int k);
        return W'(32'h25A00 + k * 32'h1013);
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, busy_o, 0);
        chk({tag, " done"}, done_o, 0);
        chk({tag, " rd_en"}, mem_rd_en_o, 0);
        chk({tag, " wr_en"}, mem_wr_en_o, 0);
        chk({tag, " addr"}, mem_addr_o, 0);
        chk({tag, " wdata"}, mem_wdata_o, 0);
        chk({tag, " wr_states"}, wr_states_o, 0);
        chk({tag, " vars_states"}, vars_states_o, 0);
    endtask

    // Load of bin at expected base address. With busy_start, both starts are
    // raised at accept and again (with another bin) during the operation.
    task automatic run_load(input logic [BW-1:0] bin, input int base,
                            input logic [LVL-1:0] max_exp, input bit busy_start);
        logic [W*N-1:0] exp_bus;
        logic [N-1:0]   exp_wr;
        start_load_i  = 1'b1;
        start_store_i = busy_start;
        bin_id_i      = bin;
        @(posedge clk); #1;
        start_load_i  = 1'b0;
        start_store_i = 1'b0;
        for (int j = 1; j <= N + 2; j++) begin
            if (busy_start && j == 3) begin
                start_load_i = 1'b1; start_store_i = 1'b1; bin_id_i = 8'd5;
            end else begin
                start_load_i = 1'b0; start_store_i = 1'b0;
            end
            exp_bus = '0;
            exp_wr  = '0;
            if (j >= 2 && j <= N + 1) begin
                exp_wr = 8'h80 >> (j - 2);
                exp_bus[W*(N-(j-2))-1 -: W] = mem[base + j - 2];
            end
            chk($sformatf("load b%0d rd_en c%0d", bin, j), mem_rd_en_o, (j <= N));
            chk($sformatf("load b%0d addr c%0d", bin, j), mem_addr_o, (j <= N) ? base + j - 1 : 0);
            chk($sformatf("load b%0d wr_en c%0d", bin, j), mem_wr_en_o, 0);
            chk($sformatf("load b%0d wr_states c%0d", bin, j), wr_states_o, exp_wr);
            chk($sformatf("load b%0d vars c%0d", bin, j), vars_states_o, exp_bus);
            chk($sformatf("load b%0d busy c%0d", bin, j), busy_o, 1);
            chk($sformatf("load b%0d done c%0d", bin, j), done_o, (j == N + 2));
            if (j == N + 2) chk($sformatf("load b%0d max_lvl", bin), max_lvl_o, max_exp);
            @(posedge clk); #1;
        end
        start_load_i = 1'b0; start_store_i = 1'b0;
        chk_idle_outputs($sformatf("after load b%0d", bin));
        @(posedge clk); #1;
        chk($sformatf("after load b%0d busy+1", bin), busy_o, 0);
    endtask

    initial begin
        logic [W*N-1:0] snap;
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W*N-1:0] snap;
        logic [15:0]    lv [0:7];
        lv[0] = 3; lv[1] = 9; lv[2] = 1; lv[3] = 0;
        lv[4] = 7; lv[5] = 9; lv[6] = 2; lv[7] = 4;

        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        for (int k = 0; k < N; k++) mem[16 + k]   = W'(32'h10 + k);
        for (int k = 0; k < N; k++) mem[8 + k]    = {3'(k), lv[k]};
        for (int k = 0; k < N; k++) mem[1016 + k] = W'(32'h7_0100 + k * 3);

        rst = 1'b1; start_load_i = 1'b0; start_store_i = 1'b0;
        bin_id_i = '0; vars_states_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        chk("reset max_lvl", max_lvl_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load bin 2: words 0x10+k at 16..23.
        run_load(8'd2, 16, MAXEN ? 16'h17 : 16'h0, 1'b0);

        // Store bin 3, engine bus changes at T+2 and must be ignored.
        for (int k = 0; k < N; k++) snap[W*(N-k)-1 -: W] = pat(k);
        vars_states_i = snap;
        start_store_i = 1'b1;
        bin_id_i      = 8'd3;
        @(posedge clk); #1;
        start_store_i = 1'b0;
        for (int j = 1; j <= N + 1; j++) begin
            if (j == 2) vars_states_i = ~snap;
            chk($sformatf("store wr_en c%0d", j), mem_wr_en_o, (j <= N));
            chk($sformatf("store addr c%0d", j), mem_addr_o, (j <= N) ? 24 + j - 1 : 0);
            chk($sformatf("store wdata c%0d", j), mem_wdata_o, (j <= N) ? pat(j - 1) : '0);
            chk($sformatf("store rd_en c%0d", j), mem_rd_en_o, 0);
            chk($sformatf("store wr_states c%0d", j), wr_states_o, 0);
            chk($sformatf("store busy c%0d", j), busy_o, 1);
            chk($sformatf("store done c%0d", j), done_o, (j == N + 1));
            @(posedge clk); #1;
        end
        chk_idle_outputs("after store");
        chk("store keeps max_lvl", max_lvl_o, MAXEN ? 16'h17 : 16'h0);
        for (int k = 0; k < N; k++)
            chk($sformatf("store mem[%0d]", 24 + k), wmem[24 + k], pat(k));
        @(posedge clk); #1;

        // Simultaneous starts: load bin 1 wins; start during busy ignored.
        run_load(8'd1, 8, MAXEN ? 16'd9 : 16'd0, 1'b1);

        // Bin 255 wraps with a 10-bit address: 1016..1023.
        run_load(8'd255, 1016, MAXEN ? 16'h0115 : 16'h0, 1'b0);

        // Reset during a load (asserted in cycle T+4).
        start_load_i = 1'b1;
        bin_id_i     = 8'd2;
        @(posedge clk); #1;
        start_load_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort wr_states before reset", wr_states_o, 8'h40);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs("abort T+5");
        chk("abort max_lvl", max_lvl_o, 0);
        rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk($sformatf("abort quiet wr_states %0d", j), wr_states_o, 0);
            chk($sformatf("abort quiet rd_en %0d", j), mem_rd_en_o, 0);
            chk($sformatf("abort quiet busy %0d", j), busy_o, 0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
